// File: rtl/risp_pkg.sv
// Shared types and helpers for the RISP spike-injector slice.
//   charge_t     : signed neuron charge at the default width
//   spike_pkt_t  : {idx, delay, charge} spike packet at the default sizes
//   clog2_min1   : $clog2 with a floor of 1 bit, for index/delay field widths
//   sat_add      : signed saturating add on integers, clamped to a given width

`define RISP_CHARGE_T(W) logic signed [(W)-1:0]

package risp_pkg;

  localparam int unsigned DefNumInp     = 1;
  localparam int unsigned DefChargeWidth = 8;
  localparam int unsigned DefMaxDelay   = 15;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefIdxW = clog2_min1(DefNumInp);
  localparam int unsigned DefDlyW = clog2_min1(DefMaxDelay + 1);

  typedef `RISP_CHARGE_T(DefChargeWidth) charge_t;

  typedef struct packed {
    logic [DefIdxW-1:0] idx;
    logic [DefDlyW-1:0] delay;
    charge_t            charge;
  } spike_pkt_t;

  function automatic int sat_add(input int a, input int b, input int unsigned cw);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (cw - 1)) - 1;
    lo = -(1 << (cw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/risp_sat_add.sv
// Signed saturating adder.
//   a, b : signed CHARGE_WIDTH operands
//   y    : a + b clamped to the representable signed range
//   sat  : high when the clamp was applied

module risp_sat_add #(
  parameter int unsigned CHARGE_WIDTH = 8
) (
  input  logic signed [CHARGE_WIDTH-1:0] a,
  input  logic signed [CHARGE_WIDTH-1:0] b,
  output logic signed [CHARGE_WIDTH-1:0] y,
  output logic                           sat
);

  logic [CHARGE_WIDTH:0] sum;

  always_comb begin
    sum = {a[CHARGE_WIDTH-1], a} + {b[CHARGE_WIDTH-1], b};
    // Overflow iff the extra sign bit disagrees with the result sign bit.
    sat = sum[CHARGE_WIDTH] != sum[CHARGE_WIDTH-1];
    if (!sat) begin
      y = sum[CHARGE_WIDTH-1:0];
    end else if (sum[CHARGE_WIDTH]) begin
      y = {1'b1, {(CHARGE_WIDTH-1){1'b0}}};
    end else begin
      y = {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/risp_spike_injector.sv
// Network input stage feeding the RISP input neurons. Spike packets {idx, delay, charge}
// are accepted over valid/ready and accumulated (saturating) into a timestep ring buffer of
// MAX_DELAY+2 slots. Each en pulse retires the current slot and advances the pointer.
//   clk, arstn   : clock, asynchronous active-low reset
//   clr          : synchronous clear, same effect as reset, beats en and packets
//   en           : timestep advance
//   pkt_*        : packet handshake and fields
//   charge       : per-neuron signed charge for the current timestep
//   pending      : some slot still holds nonzero charge
//   err          : sticky, set when a packet is dropped (bad idx or delay)

module risp_spike_injector
  import risp_pkg::*;
#(
  parameter  int unsigned NUM_INP      = 1,
  parameter  int unsigned CHARGE_WIDTH = 8,
  parameter  int unsigned MAX_DELAY    = 15,
  localparam int unsigned IDX_W        = clog2_min1(NUM_INP),
  localparam int unsigned DLY_W        = clog2_min1(MAX_DELAY + 1)
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           clr,
  input  logic                           en,
  input  logic                           pkt_valid,
  output logic                           pkt_ready,
  input  logic [IDX_W-1:0]               pkt_idx,
  input  logic [DLY_W-1:0]               pkt_delay,
  input  logic signed [CHARGE_WIDTH-1:0] pkt_charge,
  output logic signed [CHARGE_WIDTH-1:0] charge [0:NUM_INP-1],
  output logic                           pending,
  output logic                           err
);

  localparam int unsigned DEPTH = MAX_DELAY + 2;
  localparam int unsigned PTR_W = clog2_min1(DEPTH);

  logic signed [CHARGE_WIDTH-1:0] slot_q [DEPTH][NUM_INP];
  logic signed [CHARGE_WIDTH-1:0] slot_d [DEPTH][NUM_INP];
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic                           err_q, err_d;
  logic                           pending_q, pending_d;
  logic                           ready_q;

  logic                           xfer;
  logic                           idx_ok, dly_ok;
  logic [PTR_W:0]                 tgt_sum;
  logic [PTR_W-1:0]               tgt;
  logic [IDX_W-1:0]               idx_sel;
  logic signed [CHARGE_WIDTH-1:0] acc_cur;
  logic signed [CHARGE_WIDTH-1:0] acc_new;
  logic                           sat_unused;

  // ready_q rises on the first clock after reset release; clr masks it combinationally.
  assign pkt_ready = ready_q & ~clr;
  assign xfer      = pkt_valid & pkt_ready;

  assign idx_ok = {1'b0, pkt_idx} < (IDX_W + 1)'(NUM_INP);
  assign dly_ok = {1'b0, pkt_delay} <= (DLY_W + 1)'(MAX_DELAY);

  // Target slot is ptr+1+delay mod DEPTH; with a legal delay one subtraction suffices.
  always_comb begin
    tgt_sum = {1'b0, ptr_q} + (PTR_W + 1)'(1) + (PTR_W + 1)'(pkt_delay);
    if (!dly_ok) begin
      tgt = '0;
    end else if (tgt_sum >= (PTR_W + 1)'(DEPTH)) begin
      tgt = PTR_W'(tgt_sum - (PTR_W + 1)'(DEPTH));
    end else begin
      tgt = PTR_W'(tgt_sum);
    end
  end

  // Keep the read in range on packets that will be dropped anyway.
  assign idx_sel = idx_ok ? pkt_idx : '0;
  assign acc_cur = slot_q[tgt][idx_sel];

  // Clamping is silent at this stage; the adder's flag has no consumer here.
  risp_sat_add #(
    .CHARGE_WIDTH(CHARGE_WIDTH)
  ) u_sat_add (
    .a  (acc_cur),
    .b  (pkt_charge),
    .y  (acc_new),
    .sat(sat_unused)
  );

  always_comb begin
    slot_d = slot_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    if (clr) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int i = 0; i < NUM_INP; i++) begin
          slot_d[d][i] = '0;
        end
      end
      ptr_d = '0;
      err_d = 1'b0;
    end else begin
      if (en) begin
        for (int i = 0; i < NUM_INP; i++) begin
          slot_d[ptr_q][i] = '0;
        end
        ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
      // The target never equals ptr_q, so this write cannot collide with the retire above.
      if (xfer) begin
        if (idx_ok && dly_ok) begin
          slot_d[tgt][pkt_idx] = acc_new;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pending_d = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      for (int i = 0; i < NUM_INP; i++) begin
        if (slot_d[d][i] != '0) pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int i = 0; i < NUM_INP; i++) begin
          slot_q[d][i] <= '0;
        end
      end
      ptr_q     <= '0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      ready_q   <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_INP; i++) begin
      charge[i] = slot_q[ptr_q][i];
    end
  end

  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: tb/tb_risp_spike_injector.sv
module tb_risp_spike_injector;

  localparam int NI   = 3;
  localparam int CW   = 8;
  localparam int MD   = 12;
  localparam int TMAX = 1024;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic              clr = 1'b0;
  logic              en = 1'b0;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  logic [1:0]        pkt_idx = '0;
  logic [3:0]        pkt_delay = '0;
  logic signed [7:0] pkt_charge = '0;
  logic signed [7:0] charge [0:NI-1];
  logic              pending;
  logic              err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  risp_spike_injector #(
    .NUM_INP     (NI),
    .CHARGE_WIDTH(CW),
    .MAX_DELAY   (MD)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .clr       (clr),
    .en        (en),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_idx   (pkt_idx),
    .pkt_delay (pkt_delay),
    .pkt_charge(pkt_charge),
    .charge    (charge),
    .pending   (pending),
    .err       (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: charge scheduled by absolute timestep number since the last reset/clr.
  int acc [0:TMAX-1][0:NI-1];
  int tnow = 0;
  bit m_err = 1'b0;
  bit alive = 1'b0;

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < TMAX; t++)
      for (int i = 0; i < NI; i++) acc[t][i] = 0;
    tnow  = 0;
    m_err = 1'b0;
  endtask

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      model_clear();
      alive = 1'b0;
    end else begin
      if (clr) begin
        model_clear();
      end else begin
        if (pkt_valid && alive) begin
          if (int'(pkt_idx) >= NI || int'(pkt_delay) > MD) begin
            m_err = 1'b1;
          end else begin
            int t;
            t = tnow + 1 + int'(pkt_delay);
            if (t < TMAX) acc[t][pkt_idx] = clamp(acc[t][pkt_idx] + int'(pkt_charge));
          end
        end
        if (en) tnow++;
      end
      alive = 1'b1;
    end
  end

  function automatic bit model_pending();
    for (int t = tnow; t < TMAX; t++)
      for (int i = 0; i < NI; i++)
        if (acc[t][i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      chk($sformatf("cyc_charge%0d", i), int'(charge[i]), (tnow < TMAX) ? acc[tnow][i] : 0);
    chk("cyc_pending", int'(pending), int'(model_pending()));
    chk("cyc_err", int'(err), int'(m_err));
    chk("cyc_ready", int'(pkt_ready), int'(alive && !clr));
  end

  task automatic step(input bit v, input int idx, input int d, input int c, input bit e,
                      input bit cl, output bit rdy);
    @(negedge clk);
    #1;
    pkt_valid  = v;
    pkt_idx    = 2'(idx);
    pkt_delay  = 4'(d);
    pkt_charge = 8'(c);
    en         = e;
    clr        = cl;
    #1;
    rdy = pkt_ready;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic pkt(input int idx, input int d, input int c);
    bit r;
    step(1'b1, idx, d, c, 1'b0, 1'b0, r);
  endtask

  task automatic tick(input int n);
    bit r;
    repeat (n) step(1'b0, 0, 0, 0, 1'b1, 1'b0, r);
  endtask

  initial begin
    bit r;
    repeat (3) @(negedge clk);
    chk("rst_charge0", int'(charge[0]), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(pkt_ready), 0);
    #1 arstn = 1'b1;
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, r);
    chk("ready_after_rst", int'(pkt_ready), 1);

    // Basic delivery, delay 0.
    pkt(0, 0, 5);
    chk("t1_now", int'(charge[0]), 0);
    chk("t1_pending", int'(pending), 1);
    tick(1);
    chk("t1_en1", int'(charge[0]), 5);
    tick(1);
    chk("t1_en2", int'(charge[0]), 0);
    chk("t1_pending_off", int'(pending), 0);

    // Accumulation with saturation both ways.
    repeat (3) pkt(1, 3, 100);
    repeat (3) pkt(2, 4, -100);
    tick(3);
    chk("t2_en3", int'(charge[1]), 0);
    tick(1);
    chk("t2_pos_sat", int'(charge[1]), 127);
    chk("t2_err", int'(err), 0);
    tick(1);
    chk("t2_neg_sat", int'(charge[2]), -128);
    tick(1);
    chk("t2_pending_off", int'(pending), 0);

    // Max delay across the ring wrap.
    pkt(0, MD, -7);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk($sformatf("t3_en%0d", k), int'(charge[0]), (k == MD + 1) ? -7 : 0);
      if (k == MD + 1) chk("t3_pending_on", int'(pending), 1);
      if (k == MD + 2) chk("t3_pending_off", int'(pending), 0);
    end

    // Dropped packets.
    step(1'b1, NI, 0, 5, 1'b0, 1'b0, r);
    chk("t4_ready_idx", int'(r), 1);
    chk("t4_err_idx", int'(err), 1);
    step(1'b1, 0, MD + 1, 5, 1'b0, 1'b0, r);
    chk("t4_ready_dly", int'(r), 1);
    pkt(NI, MD + 1, 5);
    chk("t4_pending", int'(pending), 0);
    tick(3);
    chk("t4_err_sticky", int'(err), 1);
    chk("t4_charge0", int'(charge[0]), 0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, r);
    chk("clr_err", int'(err), 0);

    // Packet in the same cycle as en.
    chk("t5_before", int'(charge[2]), 0);
    step(1'b1, 2, 0, 3, 1'b1, 1'b0, r);
    chk("t5_after_en", int'(charge[2]), 3);
    tick(1);
    chk("t5_gone", int'(charge[2]), 0);

    // clr before delivery.
    pkt(1, 2, 9);
    chk("t6_pending_on", int'(pending), 1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, r);
    chk("t6_ready_in_clr", int'(r), 0);
    chk("t6_pending", int'(pending), 0);
    chk("t6_err", int'(err), 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("t6_en%0d", k), int'(charge[1]), 0);
    end

    // Asynchronous reset mid-schedule.
    pkt(0, 4, 20);
    @(negedge clk);
    #1 arstn = 1'b0;
    #1 chk("t7_pending_rst", int'(pending), 0);
    @(negedge clk);
    #1 arstn = 1'b1;
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, r);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk($sformatf("t7_en%0d", k), int'(charge[0]), 0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
